// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Per-button input conditioning for the seven-segment top level. Each raw
//   push-button level is passed through a two-flop synchroniser and then
//   debounced. A new level is accepted only after it has been seen at the
//   synchroniser output for DEBOUNCE_CYCLES consecutive cycles. Each accepted
//   edge produces a registered single-cycle press or release pulse.
//
//   Optional feature, enabled by defining BTN_AUTOREPEAT_EN:
//     While a button stays down, extra btn_press pulses are issued
//     REPEAT_DELAY cycles after the press pulse, and then every
//     REPEAT_PERIOD cycles after that. Without the macro, no repeat logic
//     is built and the REPEAT_* parameters have no effect.
//
// Ports
//   clk          system clock (10 MHz)
//   reset        synchronous, active-high reset
//   btn_raw      raw asynchronous button levels, 1 = pressed
//   btn_level    debounced button level
//   btn_press    one-cycle pulse per accepted press (plus auto-repeats)
//   btn_release  one-cycle pulse per accepted release
//   any_press    OR of btn_press, registered alongside it
module btn_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;
  logic [NUM_BTN-1:0] press_next_vec;
  logic               any_press_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // any_press is registered from the same next-state terms as btn_press,
  // so both outputs rise and fall on the same clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_press_reg <= 1'b0;
    end else begin
      any_press_reg <= |press_next_vec;
    end
  end

  assign any_press = any_press_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic             stable_reg;
      logic             stable_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             press_reg;
      logic             press_next;
      logic             release_reg;
      logic             release_next;
      logic             differs;
      logic             accept;
      logic             rise;
      logic             fall;
      logic             rep_fire;

      assign differs = (sync2_reg[gi] != stable_reg);
      assign accept  = differs && (cnt_reg == CNT_LAST);
      assign rise    = accept && sync2_reg[gi];
      assign fall    = accept && !sync2_reg[gi];

      // The counter only runs while the synchronised input disagrees with
      // the accepted level. Any agreement, even for one cycle, restarts the
      // count. The counter is cleared on acceptance, so it never passes
      // CNT_LAST.
      always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (differs) begin
          if (cnt_reg == CNT_LAST) begin
            stable_next = sync2_reg[gi];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

`ifdef BTN_AUTOREPEAT_EN
      localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
      localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

      logic [23:0] rcnt_reg;
      logic [23:0] rcnt_next;
      logic        rep_phase_reg;
      logic        rep_phase_next;

      // rcnt counts cycles while the level is held.
      // rep_phase chooses which interval is being timed:
      //   - 0: the initial delay before the first repeat
      //   - 1: the repeat period
      // On each repeat pulse, rcnt restarts from 0. This keeps the count
      // bounded by the longer of the two intervals.
      // The terms below clear the repeat state:
      //   - A low level clears it. This also covers the press edge, because
      //     the level is still 0 in the cycle before the press.
      //   - A release in progress clears it. This blocks a repeat that
      //     would otherwise coincide with the release cycle.
      always_comb begin
        rcnt_next      = '0;
        rep_phase_next = 1'b0;
        rep_fire       = 1'b0;
        if (stable_reg && !fall) begin
          rep_phase_next = rep_phase_reg;
          if (rcnt_reg == (rep_phase_reg ? PERIOD_LAST : DELAY_LAST)) begin
            rep_fire       = 1'b1;
            rep_phase_next = 1'b1;
          end else begin
            rcnt_next = rcnt_reg + 24'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rcnt_reg      <= '0;
          rep_phase_reg <= 1'b0;
        end else begin
          rcnt_reg      <= rcnt_next;
          rep_phase_reg <= rep_phase_next;
        end
      end
`else
      assign rep_fire = 1'b0;
`endif

      assign press_next   = rise || rep_fire;
      assign release_next = fall;

      always_ff @(posedge clk) begin
        if (reset) begin
          stable_reg  <= 1'b0;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          stable_reg  <= stable_next;
          cnt_reg     <= cnt_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      assign press_next_vec[gi] = press_next;
      assign btn_level[gi]      = stable_reg;
      assign btn_press[gi]      = press_reg;
      assign btn_release[gi]    = release_reg;
    end
  endgenerate

`ifndef BTN_AUTOREPEAT_EN
  // The repeat timing parameters only matter when auto-repeat is built.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//   Directed stimulus for btn_conditioner. The bench uses DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10 and REPEAT_PERIOD=3.
//
//   Timing conventions:
//     - cyc counts rising edges.
//     - Inputs are driven on the falling edge that follows edge cyc.
//     - Outputs are sampled on that same falling edge.
//
//   An input change driven at cyc=N first becomes visible at btn_level at
//   cyc=N+6. That is: one edge into sync1, one edge into sync2, then edge
//   DEBOUNCE_CYCLES+1 counted from the sync1 sample.
//
//   Each output event is any of:
//     - a change of btn_level
//     - a press or release pulse
//     - any_press being high
//   The stimulus pushes the expected events into exp_q. The monitor pops
//   from exp_q and compares whenever an event appears.
module tb_btn_conditioner;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  typedef struct {
    int            cyc;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          any;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_mis  = 0;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reports one line per observed output event and checks it
  // against the oldest expected event.
  logic [NB-1:0] prev_level = '0;
  ev_t           mon_exp;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (btn_level !== prev_level || btn_press !== '0 ||
          btn_release !== '0 || any_press !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_event cyc=%0d got level=%b press=%b release=%b any=%b, required no event",
                   cyc, btn_level, btn_press, btn_release, any_press);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_exp.cyc != cyc || btn_level !== mon_exp.level ||
              btn_press !== mon_exp.press || btn_release !== mon_exp.rel ||
              any_press !== mon_exp.any) begin
            n_mis++;
            $display("FAIL event got cyc=%0d level=%b press=%b release=%b any=%b, required cyc=%0d level=%b press=%b release=%b any=%b",
                     cyc, btn_level, btn_press, btn_release, any_press,
                     mon_exp.cyc, mon_exp.level, mon_exp.press, mon_exp.rel, mon_exp.any);
          end else begin
            $display("event cyc=%0d level=%b press=%b release=%b any=%b ok",
                     cyc, btn_level, btn_press, btn_release, any_press);
          end
        end
      end
      prev_level = btn_level;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [NB-1:0] lv,
                      input logic [NB-1:0] pr, input logic [NB-1:0] rl);
    ev_t e;
    e.cyc   = c;
    e.level = lv;
    e.press = pr;
    e.rel   = rl;
    e.any   = |pr;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got level=%b press=%b release=%b any=%b, required all 0",
               name, cyc, btn_level, btn_press, btn_release, any_press);
    end else begin
      $display("check %s cyc=%0d idle ok", name, cyc);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'hF;

    // 1. Reset with all buttons held. The outputs stay 0 during reset.
    //    Releasing reset at cyc 2 acts like driving the input at N=2.
    wait_cyc(1);
    check_idle("reset_cyc1");
    wait_cyc(2);
    check_idle("reset_cyc2");
    reset = 1'b0;
    push(8, 4'hF, 4'hF, 4'h0);
    wait_cyc(10);
    btn_raw = 4'h0;
    push(16, 4'h0, 4'h0, 4'hF);

    // 3. Glitch: a 3-cycle high pulse on bit 1 is rejected.
    wait_cyc(20);
    btn_raw = 4'b0010;
    wait_cyc(23);
    btn_raw = 4'b0000;
    wait_cyc(28);
    check_idle("glitch_3cyc");

    // Boundary case: a 4-cycle high pulse on bit 1 is exactly long enough
    // to be accepted.
    wait_cyc(30);
    btn_raw = 4'b0010;
    push(36, 4'b0010, 4'b0010, 4'b0000);
    wait_cyc(34);
    btn_raw = 4'b0000;
    push(40, 4'b0000, 4'b0000, 4'b0010);

    // 2. Bounce on bit 0: 2-cycle segments, then a steady 1 from cyc 53.
    wait_cyc(45); btn_raw = 4'b0001;
    wait_cyc(47); btn_raw = 4'b0000;
    wait_cyc(49); btn_raw = 4'b0001;
    wait_cyc(51); btn_raw = 4'b0000;
    wait_cyc(53); btn_raw = 4'b0001;
    push(59, 4'b0001, 4'b0001, 4'b0000);
    wait_cyc(62); btn_raw = 4'b0000;
    push(68, 4'b0000, 4'b0000, 4'b0001);

    // 4. Simultaneous press and release of bits 0 and 2.
    wait_cyc(75); btn_raw = 4'b0101;
    push(81, 4'b0101, 4'b0101, 4'b0000);
    wait_cyc(84); btn_raw = 4'b0000;
    push(90, 4'b0000, 4'b0000, 4'b0101);

    // 5. Mid-operation reset while bit 2 is held.
    //    Reset is high for edge 104 only. The level clears at that edge with
    //    no release pulse. The held button is then re-accepted as if it had
    //    been driven at N=104.
    wait_cyc(95); btn_raw = 4'b0100;
    push(101, 4'b0100, 4'b0100, 4'b0000);
    wait_cyc(103);
    reset = 1'b1;
    push(104, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(104);
    reset = 1'b0;
    push(110, 4'b0100, 4'b0100, 4'b0000);
    wait_cyc(112); btn_raw = 4'b0000;
    push(118, 4'b0000, 4'b0000, 4'b0100);

    // 6. Long hold on bit 3, press pulse at P=131.
    //    The level falls at cyc 162 (P+31). A repeat would also be due at
    //    that cycle, and it must be suppressed.
    wait_cyc(125); btn_raw = 4'b1000;
    push(131, 4'b1000, 4'b1000, 4'b0000);
`ifdef BTN_AUTOREPEAT_EN
    for (int c = 141; c <= 159; c += 3) begin
      push(c, 4'b1000, 4'b1000, 4'b0000);
    end
`endif
    wait_cyc(156); btn_raw = 4'b0000;
    push(162, 4'b0000, 4'b0000, 4'b1000);

    wait_cyc(180);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL missing_events got %0d still pending (first at cyc=%0d), required 0",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
